// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the subtractor datapath: field widths,
// special encodings and the controller state encoding.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  localparam logic [31:0]      POS_INF = 32'h7F80_0000;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SUB,
    NORM,
    PACK
  } state_t;

endpackage

// File: rtl/fp32_unpack.sv
// Splits an FP32 word into sign, exponent and a 24-bit mantissa with the
// implied leading one restored. Exponent 0 is flushed to a zero mantissa.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]      word,
  output logic             sign,
  output logic [EXP_W-1:0] exponent,
  output logic [MAN_W:0]   mantissa
);

  // Field split with denormal flush on a zero exponent
  always_comb begin
    sign     = word[31];
    exponent = word[30:23];
    if (word[30:23] == '0) begin
      mantissa = '0;
    end else begin
      mantissa = {1'b1, word[22:0]};
    end
  end

endmodule

// File: rtl/fp_sub_unit.sv
// Multi-cycle FP32 subtractor c = a - b with truncating rounding, denormal
// flush and a one-bit-per-cycle normalisation loop.
// Optional build macro FP_SUB_SPECIALS_EN: when defined, NaN/infinity
// operands are resolved in IDLE and go straight to PACK; when undefined,
// exponent 255 is an ordinary exponent and no special-value logic exists.
module fp_sub_unit
  import fp32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_c,
  output logic        o_busy,
  output logic        o_done
);

  state_t state;
  state_t next_state;

  logic             a_sign;
  logic [EXP_W-1:0] a_exp;
  logic [MAN_W:0]   a_man;
  logic             b_sign;
  logic [EXP_W-1:0] b_exp;
  logic [MAN_W:0]   b_man;

  logic             op_a_sign;
  logic [EXP_W-1:0] op_a_exp;
  logic [MAN_W:0]   op_a_man;
  logic             op_b_sign;
  logic [EXP_W-1:0] op_b_exp;
  logic [MAN_W:0]   op_b_man;

  logic             big_sign;
  logic             small_sign;
  logic [EXP_W-1:0] big_exp;
  logic [MAN_W:0]   big_man;
  logic [MAN_W:0]   small_man;

  logic             res_sign;
  logic [EXP_W-1:0] res_exp;
  logic [MAN_W:0]   res_man;

  logic             a_is_big;
  logic [EXP_W-1:0] exp_diff;
  logic [MAN_W:0]   shift_src;
  logic [MAN_W:0]   aligned_man;

  logic [MAN_W+1:0] sum_wide;
  logic [MAN_W+1:0] diff_wide;
  logic [EXP_W:0]   inc_exp;
  logic             sub_sign;
  logic [EXP_W-1:0] sub_exp;
  logic [MAN_W:0]   sub_man;

  logic             norm_done;
  logic             norm_flush;
  logic             is_special;

  fp32_unpack unpack_a (
    .word     (i_a),
    .sign     (a_sign),
    .exponent (a_exp),
    .mantissa (a_man)
  );

  fp32_unpack unpack_b (
    .word     (i_b),
    .sign     (b_sign),
    .exponent (b_exp),
    .mantissa (b_man)
  );

`ifdef FP_SUB_SPECIALS_EN
  logic        a_inf;
  logic        a_nan;
  logic        b_inf;
  logic        b_nan;
  logic [31:0] special_word;

  // Resolve NaN/infinity operands straight from the input words
  always_comb begin
    a_inf      = (a_exp == EXP_MAX) && (a_man[MAN_W-1:0] == '0);
    a_nan      = (a_exp == EXP_MAX) && (a_man[MAN_W-1:0] != '0);
    b_inf      = (b_exp == EXP_MAX) && (b_man[MAN_W-1:0] == '0);
    b_nan      = (b_exp == EXP_MAX) && (b_man[MAN_W-1:0] != '0);
    is_special = (a_exp == EXP_MAX) || (b_exp == EXP_MAX);
    if (a_nan || b_nan) begin
      special_word = QNAN;
    end else if (a_inf && b_inf) begin
      special_word = (a_sign == b_sign) ? QNAN : {a_sign, POS_INF[30:0]};
    end else if (a_inf) begin
      special_word = {a_sign, POS_INF[30:0]};
    end else begin
      special_word = {~b_sign, POS_INF[30:0]};
    end
  end
`else
  assign is_special = 1'b0;
`endif

  // Order the captured operands by magnitude and align the smaller one
  always_comb begin
    a_is_big = {op_a_exp, op_a_man} >= {op_b_exp, op_b_man};
    if (a_is_big) begin
      exp_diff  = op_a_exp - op_b_exp;
      shift_src = op_b_man;
    end else begin
      exp_diff  = op_b_exp - op_a_exp;
      shift_src = op_a_man;
    end
    if (exp_diff >= 8'd25) begin
      aligned_man = '0;
    end else begin
      aligned_man = shift_src >> exp_diff;
    end
  end

  // 25-bit magnitude add/subtract with carry renormalisation and overflow
  always_comb begin
    sum_wide  = {1'b0, big_man} + {1'b0, small_man};
    diff_wide = {1'b0, big_man} - {1'b0, small_man};
    inc_exp   = {1'b0, big_exp} + 9'd1;
    sub_sign  = big_sign;
    sub_exp   = big_exp;
    sub_man   = '0;
    if (big_sign == small_sign) begin
      if (sum_wide[MAN_W+1]) begin
        if (inc_exp >= {1'b0, EXP_MAX}) begin
          sub_exp = EXP_MAX;
          sub_man = '0;
        end else begin
          sub_exp = inc_exp[EXP_W-1:0];
          sub_man = sum_wide[MAN_W+1:1];
        end
      end else begin
        sub_man = sum_wide[MAN_W:0];
      end
    end else begin
      sub_man = diff_wide[MAN_W:0];
    end
    if ((sub_man == '0) && (sub_exp != EXP_MAX)) begin
      sub_sign = 1'b0;
      sub_exp  = '0;
    end
  end

  // Normalisation status of the working result
  always_comb begin
    norm_done  = (res_man == '0) || res_man[MAN_W];
    norm_flush = !norm_done && (res_exp <= 8'd1);
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          next_state = is_special ? PACK : ALIGN;
        end
      end
      ALIGN:   next_state = SUB;
      SUB:     next_state = NORM;
      NORM: begin
        if (norm_done || norm_flush) begin
          next_state = PACK;
        end
      end
      PACK:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy = (state != IDLE);
  end

  // Datapath registers advanced by the controller state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_c        <= '0;
      o_done     <= 1'b0;
      op_a_sign  <= 1'b0;
      op_a_exp   <= '0;
      op_a_man   <= '0;
      op_b_sign  <= 1'b0;
      op_b_exp   <= '0;
      op_b_man   <= '0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      big_exp    <= '0;
      big_man    <= '0;
      small_man  <= '0;
      res_sign   <= 1'b0;
      res_exp    <= '0;
      res_man    <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            op_a_sign <= a_sign;
            op_a_exp  <= a_exp;
            op_a_man  <= a_man;
            op_b_sign <= ~b_sign;
            op_b_exp  <= b_exp;
            op_b_man  <= b_man;
`ifdef FP_SUB_SPECIALS_EN
            if (is_special) begin
              res_sign <= special_word[31];
              res_exp  <= special_word[30:23];
              res_man  <= {1'b1, special_word[22:0]};
            end
`endif
          end
        end
        ALIGN: begin
          big_sign   <= a_is_big ? op_a_sign : op_b_sign;
          small_sign <= a_is_big ? op_b_sign : op_a_sign;
          big_exp    <= a_is_big ? op_a_exp  : op_b_exp;
          big_man    <= a_is_big ? op_a_man  : op_b_man;
          small_man  <= aligned_man;
        end
        SUB: begin
          res_sign <= sub_sign;
          res_exp  <= sub_exp;
          res_man  <= sub_man;
        end
        NORM: begin
          if (norm_flush) begin
            res_sign <= 1'b0;
            res_exp  <= '0;
            res_man  <= '0;
          end else if (!norm_done) begin
            res_man <= {res_man[MAN_W-1:0], 1'b0};
            res_exp <= res_exp - 8'd1;
          end
        end
        PACK: begin
          o_c    <= {res_sign, res_exp, res_man[MAN_W-1:0]};
          o_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_unit.sv
// Bench for fp_sub_unit: a vector table plus hand-written sequences for
// ignored starts, back-to-back requests and reset during normalisation.
// Expected results and latencies go through a scoreboard queue that a
// negedge monitor drains whenever the unit pulses done.
module tb_fp_sub_unit;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] c;
    int          lat;
    int          start;
  } sb_t;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [31:0] o_c;
  logic        o_busy;
  logic        o_done;

  int   errors     = 0;
  int   checks     = 0;
  int   cycle      = 0;
  int   done_count = 0;
  bit   mon_en     = 1'b0;
  sb_t  sb[$];
  vec_t vecs[$];

  fp_sub_unit dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_c     (o_c),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  // Free-running clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Edge counter used to measure start-to-done latency
  always @(posedge i_clk) begin
    cycle <= cycle + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: compares each done pulse and tracks busy
  always @(negedge i_clk) begin
    if (o_done) begin
      done_count++;
    end
    if (mon_en) begin
      if (o_done) begin
        checkOutput("done has pending request", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          sb_t e;
          e = sb.pop_front();
          checkOutput({e.name, " result"}, o_c, e.c);
          checkOutput({e.name, " latency"}, 32'(cycle - e.start), 32'(e.lat));
        end
      end
      if (sb.size() != 0 && cycle >= sb[0].start) begin
        checkOutput("busy during operation", {31'd0, o_busy}, 32'd1);
      end else begin
        checkOutput("busy while idle", {31'd0, o_busy}, 32'd0);
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] c,
                               input int lat, input bit sync);
    sb_t e;
    if (sync) begin
      @(negedge i_clk);
    end
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    e.name  = name;
    e.c     = c;
    e.lat   = lat;
    e.start = cycle + 1;
    sb.push_back(e);
    @(negedge i_clk);
    i_start = 1'b0;
    i_a     = $urandom;
    i_b     = $urandom;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout waiting for done: pending=%0d, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int done0;

    vecs.push_back('{"3.0-1.0",        32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4});
    vecs.push_back('{"1.0-3.0",        32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 4});
    vecs.push_back('{"1.0-0.75",       32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6});
    vecs.push_back('{"1.0-(-1.0)",     32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4});
    vecs.push_back('{"1.0-1.0",        32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4});
    vecs.push_back('{"overflow",       32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4});
    vecs.push_back('{"min-zero",       32'h0080_0000, 32'h0000_0000, 32'h0080_0000, 4});
    vecs.push_back('{"shift>=25",      32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 4});
    vecs.push_back('{"2.0-1.0",        32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 5});
    vecs.push_back('{"truncate 23sh",  32'h3F80_0000, 32'h3F7F_FFFF, 32'h3400_0000, 27});
    vecs.push_back('{"underflow",      32'h0100_0000, 32'h00C0_0000, 32'h0000_0000, 5});
    vecs.push_back('{"-1.0-1.0",       32'hBF80_0000, 32'h3F80_0000, 32'hC000_0000, 4});
    vecs.push_back('{"0-1.0",          32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 4});
    vecs.push_back('{"1.5-(-0.75)",    32'h3FC0_0000, 32'hBF40_0000, 32'h4010_0000, 4});
`ifdef FP_SUB_SPECIALS_EN
    vecs.push_back('{"inf-inf",        32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1});
    vecs.push_back('{"1.0-inf",        32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 1});
    vecs.push_back('{"nan-1.0",        32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1});
    vecs.push_back('{"inf-(-inf)",     32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000, 1});
`endif

    i_reset = 1'b1;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset o_c", o_c, 32'h0);
    checkOutput("reset o_done", {31'd0, o_done}, 32'd0);
    checkOutput("reset o_busy", {31'd0, o_busy}, 32'd0);
    i_reset = 1'b0;
    mon_en  = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].lat, 1'b1);
      waitIdle();
    end

    // A start pulse while busy must not launch a second operation
    done0 = done_count;
    applyStimulus("busy-start", 32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6, 1'b1);
    repeat (3) begin
      @(negedge i_clk);
      i_start = 1'b1;
      i_a     = $urandom;
      i_b     = $urandom;
    end
    @(negedge i_clk);
    i_start = 1'b0;
    waitIdle();
    repeat (10) @(negedge i_clk);
    checkOutput("ignored start done count", 32'(done_count - done0), 32'd1);

    // A new request presented in the done cycle is accepted at once
    applyStimulus("b2b first", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 1'b1);
    n = 0;
    while (!o_done && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (o_done) begin
      applyStimulus("b2b second", 32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 6, 1'b0);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL b2b first done: got no pulse, expected one within 50 cycles");
    end
    waitIdle();

    // Reset during normalisation aborts the operation with no done pulse
    applyStimulus("reset-in-norm", 32'h3F80_0000, 32'h3F7F_FFFF, 32'h3400_0000, 27, 1'b1);
    repeat (3) @(negedge i_clk);
    mon_en  = 1'b0;
    sb.delete();
    i_reset = 1'b1;
    @(negedge i_clk);
    checkOutput("abort o_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("abort o_c", o_c, 32'h0);
    checkOutput("abort o_done", {31'd0, o_done}, 32'd0);
    i_reset = 1'b0;
    mon_en  = 1'b1;
    done0   = done_count;
    repeat (30) @(negedge i_clk);
    checkOutput("abort no done pulse", 32'(done_count - done0), 32'd0);

    // Unit still works after the abort
    applyStimulus("after abort", 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 5, 1'b1);
    waitIdle();
    repeat (2) @(negedge i_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
